// File: rtl/gray_step_monitor.sv
// Registered monitor for a 4-bit reflected Gray stream: decodes each sample, classifies
// the move as hold/+1/-1 against the held reference, tracks position and counts illegal jumps.
module gray_step_monitor #(
   parameter int POS_W = 8,
   parameter int ERR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       gray_in,
   input  logic             gray_valid,
   input  logic             clear,
   output logic [3:0]       binary_out,
   output logic             step_valid,
   output logic             dir_up,
   output logic             dir_down,
   output logic [POS_W-1:0] position,
   output logic             err_flag,
   output logic [ERR_W-1:0] err_count,
   output logic             locked,
   output logic [1:0]       o_dbg_state
);

   // Handshake: gray_in is consumed on every rising edge where gray_valid is high;
   // there is no back-pressure, the monitor accepts one sample per cycle.

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'b00,
      ST_TRACK    = 2'b01,
      ST_FAULT    = 2'b10
   } state_t;

   localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_binary;
   logic [3:0]       w_binary_nxt;
   logic [POS_W-1:0] r_position;
   logic [POS_W-1:0] w_position_nxt;
   logic [ERR_W-1:0] r_err_count;
   logic [ERR_W-1:0] w_err_count_nxt;
   logic             r_step_valid;
   logic             r_dir_up;
   logic             r_dir_down;
   logic             r_err_flag;
   logic             r_locked;
   logic             w_step_valid_nxt;
   logic             w_dir_up_nxt;
   logic             w_dir_down_nxt;
   logic             w_err_flag_nxt;
   logic [3:0]       w_new_bin;
   logic [3:0]       w_delta;

   // Prefix-XOR Gray decode, written flat to avoid a self-referencing vector.
   always_comb begin
      w_new_bin[3] = gray_in[3];
      w_new_bin[2] = gray_in[3] ^ gray_in[2];
      w_new_bin[1] = gray_in[3] ^ gray_in[2] ^ gray_in[1];
      w_new_bin[0] = gray_in[3] ^ gray_in[2] ^ gray_in[1] ^ gray_in[0];
   end

   // binary_out doubles as the reference sample; modulo-16 wrap is the 4-bit subtract.
   assign w_delta = w_new_bin - r_binary;

   always_comb begin
      w_state_nxt      = r_state;
      w_binary_nxt     = r_binary;
      w_position_nxt   = r_position;
      w_err_count_nxt  = r_err_count;
      w_step_valid_nxt = 1'b0;
      w_dir_up_nxt     = 1'b0;
      w_dir_down_nxt   = 1'b0;
      w_err_flag_nxt   = 1'b0;

      if (clear) begin
         w_state_nxt     = ST_UNLOCKED;
         w_binary_nxt    = 4'd0;
         w_position_nxt  = '0;
         w_err_count_nxt = '0;
      end else if (gray_valid) begin
         case (r_state)
            ST_UNLOCKED, ST_FAULT: begin
               w_binary_nxt = w_new_bin;
               w_state_nxt  = ST_TRACK;
            end
            ST_TRACK: begin
               if (w_delta == 4'd1) begin
                  w_binary_nxt     = w_new_bin;
                  w_position_nxt   = r_position + POS_ONE;
                  w_step_valid_nxt = 1'b1;
                  w_dir_up_nxt     = 1'b1;
               end else if (w_delta == 4'd15) begin
                  w_binary_nxt     = w_new_bin;
                  w_position_nxt   = r_position - POS_ONE;
                  w_step_valid_nxt = 1'b1;
                  w_dir_down_nxt   = 1'b1;
               end else if (w_delta != 4'd0) begin
                  w_err_flag_nxt = 1'b1;
                  w_state_nxt    = ST_FAULT;
                  if (!(&r_err_count)) begin
                     w_err_count_nxt = r_err_count + ERR_ONE;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_UNLOCKED;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_UNLOCKED;
         r_binary     <= 4'd0;
         r_position   <= '0;
         r_err_count  <= '0;
         r_step_valid <= 1'b0;
         r_dir_up     <= 1'b0;
         r_dir_down   <= 1'b0;
         r_err_flag   <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_binary     <= w_binary_nxt;
         r_position   <= w_position_nxt;
         r_err_count  <= w_err_count_nxt;
         r_step_valid <= w_step_valid_nxt;
         r_dir_up     <= w_dir_up_nxt;
         r_dir_down   <= w_dir_down_nxt;
         r_err_flag   <= w_err_flag_nxt;
         r_locked     <= (w_state_nxt == ST_TRACK);
      end
   end

   assign binary_out  = r_binary;
   assign step_valid  = r_step_valid;
   assign dir_up      = r_dir_up;
   assign dir_down    = r_dir_down;
   assign position    = r_position;
   assign err_flag    = r_err_flag;
   assign err_count   = r_err_count;
   assign locked      = r_locked;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: directed test-plan steps followed by randomized samples,
// every cycle compared against a sample-level reference model.
module tb_gray_step_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] gray_in = 4'd0;
   logic       gray_valid = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] binary_out;
   logic       step_valid;
   logic       dir_up;
   logic       dir_down;
   logic [7:0] position;
   logic       err_flag;
   logic [3:0] err_count;
   logic       locked;
   logic [1:0] dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: whether a reference is held, its binary value, position and errors.
   bit m_locked;
   int m_ref, m_pos, m_err;
   bit e_step, e_up, e_dn, e_err;

   gray_step_monitor #(.POS_W(8), .ERR_W(4)) dut (
      .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid), .clear(clear),
      .binary_out(binary_out), .step_valid(step_valid), .dir_up(dir_up), .dir_down(dir_down),
      .position(position), .err_flag(err_flag), .err_count(err_count), .locked(locked),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] gray_of(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic int bin_of(input logic [3:0] g);
      for (int b = 0; b < 16; b++) if (gray_of(b) == g) return b;
      return 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_ref = 0; m_pos = 0; m_err = 0;
      e_step = 0; e_up = 0; e_dn = 0; e_err = 0;
   endtask

   task automatic model_update(input logic [3:0] g, input logic v, input logic c);
      int nb, d;
      e_step = 0; e_up = 0; e_dn = 0; e_err = 0;
      if (c) begin
         m_pos = 0; m_err = 0; m_ref = 0; m_locked = 0;
      end else if (v) begin
         nb = bin_of(g);
         if (!m_locked) begin
            m_ref = nb; m_locked = 1;
         end else begin
            d = (nb - m_ref + 16) % 16;
            if (d == 1) begin
               m_ref = nb; m_pos = (m_pos + 1) % 256; e_step = 1; e_up = 1;
            end else if (d == 15) begin
               m_ref = nb; m_pos = (m_pos + 255) % 256; e_step = 1; e_dn = 1;
            end else if (d != 0) begin
               e_err = 1; m_err = (m_err < 15) ? m_err + 1 : 15; m_locked = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      check("binary_out", 32'(binary_out), 32'(m_ref));
      check("step_valid", 32'(step_valid), 32'(e_step));
      check("dir_up",     32'(dir_up),     32'(e_up));
      check("dir_down",   32'(dir_down),   32'(e_dn));
      check("position",   32'(position),   32'(m_pos));
      check("err_flag",   32'(err_flag),   32'(e_err));
      check("err_count",  32'(err_count),  32'(m_err));
      check("locked",     32'(locked),     32'(m_locked));
   endtask

   task automatic step(input logic [3:0] g, input logic v, input logic c);
      @(negedge clk);
      gray_in = g; gray_valid = v; clear = c;
      @(posedge clk);
      #1;
      model_update(g, v, c);
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; gray_valid = 1'b0; clear = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_all();
   endtask

   initial begin
      int up_cnt;
      int nb, k, r;
      logic v, c;

      // Reset values
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      check("rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset then lock
      step(4'b0011, 1, 0);
      check("lock_bin", 32'(binary_out), 32'h2);
      check("lock_locked", 32'(locked), 32'd1);

      // Full up sweep with wrap
      do_reset();
      up_cnt = 0;
      for (int i = 0; i <= 16; i++) begin
         step(gray_of(i % 16), 1, 0);
         up_cnt += int'(dir_up);
      end
      check("sweep_ups", 32'(up_cnt), 32'd16);
      check("sweep_pos", 32'(position), 32'd16);
      check("sweep_err", 32'(err_count), 32'd0);

      // Down with position wrap
      step(4'b0000, 1, 1);
      step(4'b0000, 1, 0);
      step(4'b1000, 1, 0);
      check("down_pulse", 32'(dir_down), 32'd1);
      check("down_pos", 32'(position), 32'hFF);
      check("down_bin", 32'(binary_out), 32'hF);

      // Illegal single-bit jump then resync
      step(4'b0000, 1, 1);
      step(4'b0000, 1, 0);
      step(4'b0100, 1, 0);
      check("illegal_flag", 32'(err_flag), 32'd1);
      check("illegal_locked", 32'(locked), 32'd0);
      check("illegal_bin", 32'(binary_out), 32'h0);
      step(4'b0101, 1, 0);
      check("resync_bin", 32'(binary_out), 32'h6);
      check("resync_locked", 32'(locked), 32'd1);

      // Saturation: illegal jump / resync pairs
      for (int i = 0; i < 20; i++) begin
         step(gray_of((m_ref + 7) % 16), 1, 0);
         step(gray_of($urandom_range(0, 15)), 1, 0);
      end
      check("err_sat", 32'(err_count), 32'hF);
      step(gray_of((m_ref + 5) % 16), 1, 0);
      check("err_sat_flag", 32'(err_flag), 32'd1);
      step(gray_of(m_ref), 1, 0);

      // Hold: repeated sample and idle cycles
      for (int i = 0; i < 4; i++) step(gray_of(m_ref), 1, 0);
      for (int i = 0; i < 4; i++) step(4'($urandom_range(0, 15)), 0, 0);

      // Clear wins over a valid up step
      step(gray_of((m_ref + 1) % 16), 1, 1);
      check("clear_pos", 32'(position), 32'd0);
      check("clear_step", 32'(step_valid), 32'd0);

      // Randomized stream
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         v = (r < 80);
         c = (r >= 97);
         k = $urandom_range(0, 9);
         if (!m_locked || k >= 8) nb = $urandom_range(0, 15);
         else if (k < 2) nb = m_ref;
         else if (k < 5) nb = (m_ref + 1) % 16;
         else nb = (m_ref + 15) % 16;
         step(gray_of(nb), v, c);
      end

      // Asynchronous reset between clock edges
      step(4'b0000, 1, 1);
      step(gray_of(0), 1, 0);
      step(gray_of(1), 1, 0);
      step(gray_of(2), 1, 0);
      @(negedge clk);
      gray_in = gray_of(3); gray_valid = 1'b1; clear = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      check("async_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      gray_valid = 1'b0;
      rst = 1'b0;
      step(gray_of(9), 1, 0);
      check("post_rst_lock", 32'(step_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
